// File: rtl/mdio_arbiter_if.sv
//----------------------------------------------------------------------------
// Module      : mdio_arbiter_if
// Description : Client, MDIO-engine and PHY-status signals of mdio_arbiter.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface mdio_arbiter_if;
    logic        c0_req;
    logic        c0_we;
    logic [4:0]  c0_addr;
    logic [15:0] c0_wdata;
    logic        c0_done;
    logic [15:0] c0_rdata;
    logic        c0_err;

    logic        c1_req;
    logic        c1_we;
    logic [4:0]  c1_addr;
    logic [15:0] c1_wdata;
    logic        c1_done;
    logic [15:0] c1_rdata;
    logic        c1_err;

    logic [4:0]  mdio_addr;
    logic [15:0] mdio_wr_data;
    logic        mdio_rd_request;
    logic        mdio_wr_request;
    logic        mdio_ready;
    logic [15:0] mdio_rd_data;

    logic [1:0]  speed;
    logic        duplex;
    logic        status_valid;

    // Arbiter side
    modport slave (
        input  c0_req, c0_we, c0_addr, c0_wdata,
        output c0_done, c0_rdata, c0_err,
        input  c1_req, c1_we, c1_addr, c1_wdata,
        output c1_done, c1_rdata, c1_err,
        output mdio_addr, mdio_wr_data, mdio_rd_request, mdio_wr_request,
        input  mdio_ready, mdio_rd_data,
        output speed, duplex, status_valid
    );

    // Clients and engine side
    modport master (
        output c0_req, c0_we, c0_addr, c0_wdata,
        input  c0_done, c0_rdata, c0_err,
        output c1_req, c1_we, c1_addr, c1_wdata,
        input  c1_done, c1_rdata, c1_err,
        input  mdio_addr, mdio_wr_data, mdio_rd_request, mdio_wr_request,
        output mdio_ready, mdio_rd_data,
        input  speed, duplex, status_valid
    );
endinterface

`default_nettype wire

// File: rtl/mdio_arbiter.sv
//----------------------------------------------------------------------------
// Module      : mdio_arbiter
// Description : Round-robin arbiter of two clients plus a periodic PHY status
//               poll onto a single MDIO engine, with transaction timeout.
// Revision    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mdio_arbiter #(
    parameter int unsigned POLL_PERIOD = 250000,
    parameter int unsigned POLL_ADDR   = 31,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mdio_arbiter_if.slave     bus
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ISSUE     = 3'd1;
    localparam logic [2:0] c_WAIT_BUSY = 3'd2;
    localparam logic [2:0] c_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_COMPLETE  = 3'd4;

    localparam logic [1:0] c_GNT_C0   = 2'd0;
    localparam logic [1:0] c_GNT_C1   = 2'd1;
    localparam logic [1:0] c_GNT_POLL = 2'd2;

    localparam int              c_TW        = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_T_LAST    = c_TW'(TIMEOUT - 1);
    localparam logic [31:0]     c_POLL_LAST = 32'(POLL_PERIOD - 1);
    localparam logic [4:0]      c_POLL_ADDR = 5'(POLL_ADDR);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [1:0]      r_grant;
    logic            r_last;
    logic            r_we;
    logic [4:0]      r_addr;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic            r_err;
    logic [c_TW-1:0] r_tcnt;
    logic [31:0]     r_poll_cnt;
    logic            r_poll_pending;
    logic            r_poll_urgent;
    logic [1:0]      r_speed;
    logic            r_duplex;
    logic            r_status_valid;

    logic            w_arb_valid;
    logic [1:0]      w_arb_grant;
    logic            w_timeout;
    logic            w_poll_wrap;
    logic            w_poll_take;
    logic            w_issue;
    logic            w_done;

    // A poll left pending across a whole period is urgent and beats both clients.
    always_comb begin
        w_arb_valid = 1'b1;
        w_arb_grant = c_GNT_POLL;
        if (r_poll_urgent)
            w_arb_grant = c_GNT_POLL;
        else if (bus.c0_req && bus.c1_req)
            w_arb_grant = r_last ? c_GNT_C0 : c_GNT_C1;
        else if (bus.c0_req)
            w_arb_grant = c_GNT_C0;
        else if (bus.c1_req)
            w_arb_grant = c_GNT_C1;
        else if (r_poll_pending)
            w_arb_grant = c_GNT_POLL;
        else
            w_arb_valid = 1'b0;
    end

    assign w_timeout   = (r_tcnt == c_T_LAST);
    assign w_poll_wrap = (r_poll_cnt == c_POLL_LAST);
    assign w_poll_take = (r_state == c_IDLE) && w_arb_valid && (w_arb_grant == c_GNT_POLL);

    always_ff @(posedge clock) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:      if (w_arb_valid) w_next = c_ISSUE;
            c_ISSUE:     if (bus.mdio_ready) w_next = c_WAIT_BUSY;
            c_WAIT_BUSY: begin
                if (w_timeout)            w_next = c_COMPLETE;
                else if (!bus.mdio_ready) w_next = c_WAIT_DONE;
            end
            c_WAIT_DONE: if (bus.mdio_ready || w_timeout) w_next = c_COMPLETE;
            c_COMPLETE:  w_next = c_IDLE;
            default:     w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_issue              = !reset && (r_state == c_ISSUE) && bus.mdio_ready;
        w_done               = !reset && (r_state == c_COMPLETE);
        bus.mdio_addr        = r_addr;
        bus.mdio_wr_data     = r_wdata;
        bus.mdio_rd_request  = w_issue && !r_we;
        bus.mdio_wr_request  = w_issue && r_we;
        bus.c0_done          = w_done && (r_grant == c_GNT_C0);
        bus.c1_done          = w_done && (r_grant == c_GNT_C1);
        bus.c0_rdata         = bus.c0_done ? r_rdata : 16'h0000;
        bus.c1_rdata         = bus.c1_done ? r_rdata : 16'h0000;
        bus.c0_err           = bus.c0_done && r_err;
        bus.c1_err           = bus.c1_done && r_err;
        bus.speed            = r_speed;
        bus.duplex           = r_duplex;
        bus.status_valid     = r_status_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant        <= c_GNT_C0;
            r_last         <= 1'b1;
            r_we           <= 1'b0;
            r_addr         <= 5'd0;
            r_wdata        <= 16'h0000;
            r_rdata        <= 16'h0000;
            r_err          <= 1'b0;
            r_tcnt         <= '0;
            r_poll_cnt     <= 32'd0;
            r_poll_pending <= 1'b0;
            r_poll_urgent  <= 1'b0;
            r_speed        <= 2'b00;
            r_duplex       <= 1'b0;
            r_status_valid <= 1'b0;
        end else begin
            r_poll_cnt     <= w_poll_wrap ? 32'd0 : r_poll_cnt + 32'd1;
            r_poll_pending <= !w_poll_take && (r_poll_pending || w_poll_wrap);
            r_poll_urgent  <= !w_poll_take && (r_poll_urgent || (w_poll_wrap && r_poll_pending));

            case (r_state)
                c_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_grant;
                        case (w_arb_grant)
                            c_GNT_C0: begin
                                r_addr  <= bus.c0_addr;
                                r_we    <= bus.c0_we;
                                r_wdata <= bus.c0_wdata;
                                r_last  <= 1'b0;
                            end
                            c_GNT_C1: begin
                                r_addr  <= bus.c1_addr;
                                r_we    <= bus.c1_we;
                                r_wdata <= bus.c1_wdata;
                                r_last  <= 1'b1;
                            end
                            default: begin
                                r_addr  <= c_POLL_ADDR;
                                r_we    <= 1'b0;
                                r_wdata <= 16'h0000;
                            end
                        endcase
                    end
                end
                c_ISSUE: r_tcnt <= '0;
                c_WAIT_BUSY, c_WAIT_DONE: begin
                    r_tcnt <= r_tcnt + c_TW'(1);
                    if ((r_state == c_WAIT_DONE) && bus.mdio_ready) begin
                        r_rdata <= r_we ? 16'h0000 : bus.mdio_rd_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 16'hFFFF;
                        r_err   <= 1'b1;
                    end
                end
                c_COMPLETE: begin
                    // A failed poll invalidates the status but keeps the last known speed/duplex.
                    if (r_grant == c_GNT_POLL) begin
                        if (r_err) begin
                            r_status_valid <= 1'b0;
                        end else begin
                            r_speed        <= r_rdata[6:5];
                            r_duplex       <= r_rdata[3];
                            r_status_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
